// File: rtl/egress_pkg.sv
// ----------------------------------------------------------------------------
// egress_pkg: header layout, register map and FSM states shared by egress blocks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package egress_pkg;

  localparam int LEN_MSB         = 26;
  localparam int LEN_LSB         = 21;
  localparam int LEN_W           = LEN_MSB - LEN_LSB + 1;
  localparam int WORDS_PER_BLOCK = 8;

  localparam logic [2:0] REG_PKT_COUNT  = 3'd0;
  localparam logic [2:0] REG_WORD_COUNT = 3'd1;
  localparam logic [2:0] REG_ERR_COUNT  = 3'd2;
  localparam logic [2:0] REG_LAT_MIN    = 3'd3;
  localparam logic [2:0] REG_LAT_MAX    = 3'd4;
  localparam logic [2:0] REG_LAT_SUM    = 3'd5;
  localparam logic [2:0] REG_STATUS     = 3'd6;
  localparam logic [2:0] REG_POP        = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MAC     = 2'd1,
    TS      = 2'd2,
    PAYLOAD = 2'd3
  } state_e;

  // Index of the final word of a packet whose header carries len.
  function automatic logic [8:0] pkt_last_idx(input logic [LEN_W-1:0] len);
    return 9'((10'(len) + 10'd1) * 10'(WORDS_PER_BLOCK) - 10'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/egress_monitor_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo: single-clock FIFO; a push while full is accepted only with a pop
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/egress_monitor.sv
// ----------------------------------------------------------------------------
// egress_monitor: packet reassembly, switch-latency statistics and latency FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module egress_monitor
  import egress_pkg::*;
#(
  parameter int PORT_ID        = 0,
  parameter int LAT_FIFO_DEPTH = 16,
  parameter int TIMEOUT        = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word_in,
  input  logic        word_in_en,
  input  logic [31:0] time_now,
  input  logic        clr,
  input  logic        rd_en,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        pkt_done,
  output logic        err
);

  localparam int SW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(LAT_FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [8:0]       word_cnt_q, word_cnt_d;
  logic [31:0]      ts_q, ts_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [31:0]      pkt_count_q, pkt_count_d, word_count_q, word_count_d;
  logic [31:0]      err_count_q, err_count_d, lat_sum_q, lat_sum_d;
  logic [31:0]      lat_min_q, lat_min_d, lat_max_q, lat_max_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             ovf_q, ovf_d, pkt_done_q, pkt_done_d, err_q, err_d;

  logic             complete, abort, future;
  logic [31:0]      ts_ahead, lat;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [31:0]      fifo_head;

  // A timestamp less than half the time range ahead of now is in the future.
  assign ts_ahead  = ts_q - time_now;
  assign future    = (ts_q > time_now) && !ts_ahead[31];
  assign lat       = future ? 32'd0 : (time_now - ts_q);
  assign fifo_push = complete && !clr;
  assign fifo_pop  = rd_en && (rd_addr == REG_POP);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    ts_d       = ts_q;
    stall_d    = stall_q;
    complete   = 1'b0;
    abort      = 1'b0;
    if (word_in_en) begin
      stall_d = '0;
      case (state_q)
        IDLE: begin
          len_d      = word_in[LEN_MSB:LEN_LSB];
          word_cnt_d = 9'd1;
          state_d    = MAC;
        end
        MAC: begin
          word_cnt_d = 9'd2;
          state_d    = TS;
        end
        TS: begin
          ts_d       = word_in;
          word_cnt_d = 9'd3;
          state_d    = PAYLOAD;
        end
        default: begin
          if (word_cnt_q == pkt_last_idx(len_q)) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            word_cnt_d = word_cnt_q + 9'd1;
          end
        end
      endcase
    end else if (state_q != IDLE) begin
      if (stall_q == SW'(TIMEOUT - 1)) begin
        abort   = 1'b1;
        stall_d = '0;
        state_d = IDLE;
      end else begin
        stall_d = stall_q + SW'(1);
      end
    end
  end

  always_comb begin
    pkt_count_d  = pkt_count_q;
    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    lat_sum_d    = lat_sum_q;
    lat_min_d    = lat_min_q;
    lat_max_d    = lat_max_q;
    ovf_d        = ovf_q;
    if (clr) begin
      pkt_count_d  = '0;
      word_count_d = '0;
      err_count_d  = '0;
      lat_sum_d    = '0;
      lat_min_d    = '1;
      lat_max_d    = '0;
      ovf_d        = 1'b0;
    end else begin
      if (word_in_en && word_count_q != '1) word_count_d = word_count_q + 32'd1;
      if ((abort || (complete && future)) && err_count_q != '1)
        err_count_d = err_count_q + 32'd1;
      if (complete) begin
        if (pkt_count_q != '1) pkt_count_d = pkt_count_q + 32'd1;
        lat_sum_d = lat_sum_q + lat;
        if (lat < lat_min_q) lat_min_d = lat;
        if (lat > lat_max_q) lat_max_d = lat;
      end
      if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    pkt_done_d = complete;
    err_d      = abort || (complete && future);
    if (rd_en) begin
      case (rd_addr)
        REG_PKT_COUNT:  rd_data_d = pkt_count_q;
        REG_WORD_COUNT: rd_data_d = word_count_q;
        REG_ERR_COUNT:  rd_data_d = err_count_q;
        REG_LAT_MIN:    rd_data_d = lat_min_q;
        REG_LAT_MAX:    rd_data_d = lat_max_q;
        REG_LAT_SUM:    rd_data_d = lat_sum_q;
        REG_STATUS:     rd_data_d = {2'(PORT_ID), 21'b0, ovf_q, fifo_empty, 7'(fifo_count)};
        default:        rd_data_d = fifo_empty ? 32'd0 : fifo_head;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      ts_q         <= '0;
      stall_q      <= '0;
      pkt_count_q  <= '0;
      word_count_q <= '0;
      err_count_q  <= '0;
      lat_sum_q    <= '0;
      lat_min_q    <= '1;
      lat_max_q    <= '0;
      ovf_q        <= 1'b0;
      rd_data_q    <= '0;
      pkt_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      ts_q         <= ts_d;
      stall_q      <= stall_d;
      pkt_count_q  <= pkt_count_d;
      word_count_q <= word_count_d;
      err_count_q  <= err_count_d;
      lat_sum_q    <= lat_sum_d;
      lat_min_q    <= lat_min_d;
      lat_max_q    <= lat_max_d;
      ovf_q        <= ovf_d;
      rd_data_q    <= rd_data_d;
      pkt_done_q   <= pkt_done_d;
      err_q        <= err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign pkt_done = pkt_done_q;
  assign err      = err_q;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (LAT_FIFO_DEPTH)
  ) u_lat_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .push  (fifo_push),
    .wdata (lat),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_egress_monitor.sv
// ----------------------------------------------------------------------------
// tb_egress_monitor: packet-level reference model, vector table and random packets
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_egress_monitor;

  localparam int PORT_ID = 2;
  localparam int DEPTH   = 16;
  localparam int TO      = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_in_en = 1'b0;
  logic [31:0] time_now = '0;
  logic        clr = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        pkt_done;
  logic        err;

  always #5 clk = ~clk;

  egress_monitor #(
    .PORT_ID        (PORT_ID),
    .LAT_FIFO_DEPTH (DEPTH),
    .TIMEOUT        (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .word_in    (word_in),
    .word_in_en (word_in_en),
    .time_now   (time_now),
    .clr        (clr),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pkt_done   (pkt_done),
    .err        (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: statistics as plain numbers, the latency FIFO as a queue.
  bit [31:0] m_pkt, m_word, m_err, m_min, m_max, m_sum;
  bit        m_ovf;
  bit [31:0] m_q[$];

  typedef struct {
    int          len;
    logic [31:0] ts;
    logic [31:0] tnow;
    int          stall_after;
    int          stall_cyc;
    logic        exp_err;
    logic [31:0] exp_lat;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_pkt = 0; m_word = 0; m_err = 0; m_sum = 0; m_max = 0;
    m_min = 32'hFFFF_FFFF; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic check_pop(input string name);
    logic [31:0] d, e;
    e = (m_q.size() != 0) ? m_q.pop_front() : 32'd0;
    rd(3'd7, d);
    check(name, d, e);
  endtask

  task automatic check_regs(input string name);
    logic [31:0] d, e;
    for (int a = 0; a < 7; a++) begin
      case (a)
        0: e = m_pkt;
        1: e = m_word;
        2: e = m_err;
        3: e = m_min;
        4: e = m_max;
        5: e = m_sum;
        default: e = {2'(PORT_ID), 21'b0, m_ovf, (m_q.size() == 0), 7'(m_q.size())};
      endcase
      rd(3'(a), d);
      check($sformatf("%s/reg%0d", name, a), d, e);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_clear();
  endtask

  task automatic send_pkt(input int len, input logic [31:0] ts, input logic [31:0] tnow,
                          input int stall_after, input int stall_cyc,
                          input bit clr_last, input bit pop_last,
                          input string name, output logic got_err);
    int          n, errs;
    bit          fut, last;
    logic [31:0] lat, exp_rd, hdr;
    n   = 8 * (len + 1);
    fut = (ts > tnow) && ((ts - tnow) < 32'h8000_0000);
    lat = fut ? 32'd0 : (tnow - ts);
    errs = 0;
    time_now = tnow;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      hdr  = $urandom;
      hdr[26:21] = 6'(len);
      word_in_en = 1'b1;
      word_in    = (i == 0) ? hdr : (i == 2) ? ts : $urandom;
      clr        = clr_last && last;
      rd_en      = pop_last && last;
      rd_addr    = 3'd7;
      step();
      word_in_en = 1'b0; clr = 1'b0; rd_en = 1'b0;
      if (!last && i == stall_after)
        for (int k = 0; k < stall_cyc; k++) begin
          step();
          errs += int'(err);
        end
    end
    got_err = err;
    if (stall_cyc > 0) check({name, "/stall_err"}, errs, 0);
    m_word += n;
    if (clr_last) begin
      model_clear();
    end else begin
      if (pop_last) begin
        exp_rd = (m_q.size() != 0) ? m_q.pop_front() : 32'd0;
        check({name, "/pop_rd"}, rd_data, exp_rd);
      end
      m_pkt++;
      m_sum += lat;
      if (lat < m_min) m_min = lat;
      if (lat > m_max) m_max = lat;
      if (fut) m_err++;
      if (m_q.size() < DEPTH) m_q.push_back(lat); else m_ovf = 1;
      check({name, "/done"}, pkt_done, 1);
      check({name, "/err"}, err, fut);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          errs, len, sa, sc;
    logic [31:0] ts, tn;

    tbl[0] = '{1, 32'd2000,        32'd2003,     4,  5, 1'b0, 32'd3};
    tbl[1] = '{2, 32'd1000,        32'd1500,     8, 10, 1'b0, 32'd500};
    tbl[2] = '{0, 32'hFFFF_FFF0,   32'h10,       0,  0, 1'b0, 32'h20};
    tbl[3] = '{0, 32'd500,         32'd400,      0,  0, 1'b1, 32'd0};
    tbl[4] = '{0, 32'h8000_0190,   32'd400,      0,  0, 1'b0, 32'h8000_0000};
    tbl[5] = '{0, 32'h8000_018F,   32'd400,      0,  0, 1'b1, 32'd0};
    tbl[6] = '{3, 32'd12345,       32'd12345,    5,  1, 1'b0, 32'd0};
    tbl[7] = '{63, 32'd7,          32'd1007,   300, 63, 1'b0, 32'd1000};

    model_clear();
    step(); step(); step();
    check("reset/rd_data", rd_data, 0);
    check("reset/pkt_done", pkt_done, 0);
    check("reset/err", err, 0);
    reset = 1'b1;
    step();
    check_regs("reset");

    // Basic LEN=0 packet with fixed expectations.
    send_pkt(0, 32'd100, 32'd140, 0, 0, 0, 0, "basic", e);
    step();
    check("basic/pulse_once", pkt_done, 0);
    rd(3'd0, d); check("basic/pkt_count", d, 1);
    rd(3'd1, d); check("basic/word_count", d, 8);
    rd(3'd3, d); check("basic/lat_min", d, 40);
    rd(3'd4, d); check("basic/lat_max", d, 40);
    rd(3'd5, d); check("basic/lat_sum", d, 40);
    check_pop("basic/pop1");
    check_pop("basic/pop_empty");

    // Mid-packet timeout abort; the following word must start a new packet.
    time_now = 32'd0;
    for (int i = 0; i < 10; i++) begin
      word_in_en = 1'b1;
      word_in    = (i == 0) ? (32'd2 << 21) : $urandom;
      step();
    end
    word_in_en = 1'b0;
    errs = 0;
    for (int k = 0; k < TO + 6; k++) begin
      step();
      errs += int'(err);
    end
    check("abort/err_pulses", errs, 1);
    m_word += 10;
    m_err++;
    check_regs("abort");
    send_pkt(0, 32'd10, 32'd20, 0, 0, 0, 0, "after_abort", e);
    check_pop("after_abort/pop");

    // Vector table.
    for (int t = 0; t < 8; t++) begin
      send_pkt(tbl[t].len, tbl[t].ts, tbl[t].tnow, tbl[t].stall_after, tbl[t].stall_cyc,
               0, 0, $sformatf("tbl%0d", t), e);
      check($sformatf("tbl%0d/exp_err", t), e, tbl[t].exp_err);
      rd(3'd7, d);
      check($sformatf("tbl%0d/lat", t), d, tbl[t].exp_lat);
      if (m_q.size() != 0) void'(m_q.pop_front());
    end
    check_regs("tbl");

    // FIFO overflow, then push and pop together while full.
    do_clr();
    for (int i = 0; i < 17; i++)
      send_pkt(0, 32'd0, 32'(i * 3 + 5), 0, 0, 0, 0, $sformatf("ovf%0d", i), e);
    check_regs("ovf");
    send_pkt(0, 32'd0, 32'd999, 0, 0, 0, 1, "full_pushpop", e);
    check_regs("full_pushpop");
    for (int i = 0; i < 17; i++) check_pop($sformatf("drain%0d", i));
    check_regs("drained");

    // Clear coinciding with the last word of a packet.
    send_pkt(1, 32'd5, 32'd55, 0, 0, 0, 0, "pre_clr", e);
    send_pkt(0, 32'd5, 32'd99, 0, 0, 1, 0, "clr_last", e);
    check_regs("clr_last");

    // Randomized packets against the model.
    for (int r = 0; r < 30; r++) begin
      len = $urandom_range(0, 3);
      ts  = $urandom;
      tn  = ($urandom_range(0, 2) != 0) ? ts + 32'($urandom_range(0, 100000)) : 32'($urandom);
      sa  = $urandom_range(1, 8 * (len + 1) - 2);
      sc  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO - 1) : 0;
      send_pkt(len, ts, tn, sa, sc, 0, ($urandom_range(0, 3) == 0),
               $sformatf("rnd%0d", r), e);
      if ($urandom_range(0, 1) != 0) check_pop($sformatf("rnd%0d/pop", r));
    end
    check_regs("rnd");

    // Reset asserted in the middle of a packet payload.
    rd(3'd1, d);
    time_now = 32'd0;
    for (int i = 0; i < 6; i++) begin
      word_in_en = 1'b1;
      word_in    = (i == 0) ? (32'd1 << 21) : $urandom;
      step();
    end
    word_in_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst/rd_data", rd_data, 0);
    check("midrst/pkt_done", pkt_done, 0);
    check("midrst/err", err, 0);
    step(); step();
    reset = 1'b1;
    model_clear();
    step();
    send_pkt(1, 32'd50, 32'd77, 0, 0, 0, 0, "post_rst", e);
    check_regs("post_rst");
    check_pop("post_rst/pop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
